// File: rtl/cargador_programa.sv
`default_nettype none
// ============================================================================
// Module   : cargador_programa
// Brief    : Program loader plus 2**ANCHO_DIR-byte instruction memory with a
//            4-byte combinational fetch port. Optional trailing checksum byte
//            is enabled by defining CARGA_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cargador_programa #(
    parameter int ANCHO_DIR  = 8,
    parameter int ANCHO_DATO = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic [ANCHO_DATO-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ocupado,
    output logic                  cargado,
    output logic                  error,
    input  logic [ANCHO_DIR-1:0]  Direccion,
    output logic [ANCHO_DATO-1:0] B1,
    output logic [ANCHO_DATO-1:0] B2,
    output logic [ANCHO_DATO-1:0] B3,
    output logic [ANCHO_DATO-1:0] B4
);

    localparam int CW = ANCHO_DIR + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   total_q,  total_d;
    logic [CW-1:0]   cuenta_q, cuenta_d;
    logic [CW-1:0]   w_cuenta_sig;
    logic            w_acepta;
    logic            w_escribe;
`ifdef CARGA_CHECKSUM_EN
    logic [ANCHO_DATO-1:0] suma_q, suma_d;
`endif

    logic [ANCHO_DATO-1:0] mem [2**ANCHO_DIR];

    assign in_ready     = (estado_q == S_HEADER) || (estado_q == S_DATA) || (estado_q == S_CHECK);
    assign ocupado      = in_ready || (estado_q == S_ERROR);
    assign cargado      = (estado_q == S_DONE);
`ifdef CARGA_CHECKSUM_EN
    assign error        = (estado_q == S_ERROR);
`else
    assign error        = 1'b0;
`endif
    assign w_acepta     = in_valid && in_ready;
    assign w_escribe    = w_acepta && (estado_q == S_DATA);
    assign w_cuenta_sig = cuenta_q + CW'(1);

    always_comb begin
        estado_d = estado_q;
        total_d  = total_q;
        cuenta_d = cuenta_q;
`ifdef CARGA_CHECKSUM_EN
        suma_d   = suma_q;
`endif
        case (estado_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (inicio) estado_d = S_HEADER;
            end
            S_HEADER: begin
                if (w_acepta) begin
                    // A zero header means a full-depth image
                    total_d  = (in_data == '0) ? CW'(2**ANCHO_DIR) : CW'(in_data);
                    cuenta_d = '0;
`ifdef CARGA_CHECKSUM_EN
                    suma_d   = '0;
`endif
                    estado_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_acepta) begin
                    cuenta_d = w_cuenta_sig;
`ifdef CARGA_CHECKSUM_EN
                    suma_d   = suma_q + in_data;
                    if (w_cuenta_sig == total_q) estado_d = S_CHECK;
`else
                    if (w_cuenta_sig == total_q) estado_d = S_DONE;
`endif
                end
            end
`ifdef CARGA_CHECKSUM_EN
            S_CHECK: begin
                if (w_acepta) estado_d = (in_data == suma_q) ? S_DONE : S_ERROR;
            end
`endif
            default: estado_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= S_IDLE;
            total_q  <= '0;
            cuenta_q <= '0;
`ifdef CARGA_CHECKSUM_EN
            suma_q   <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            total_q  <= total_d;
            cuenta_q <= cuenta_d;
`ifdef CARGA_CHECKSUM_EN
            suma_q   <= suma_d;
`endif
        end
    end

    // Memory is never cleared so a reset keeps whatever was already loaded
    always_ff @(posedge clk) begin
        if (!reset && w_escribe) mem[cuenta_q[ANCHO_DIR-1:0]] <= in_data;
    end

    assign B1 = mem[Direccion];
    assign B2 = mem[Direccion + ANCHO_DIR'(1)];
    assign B3 = mem[Direccion + ANCHO_DIR'(2)];
    assign B4 = mem[Direccion + ANCHO_DIR'(3)];

endmodule
`default_nettype wire

// File: tb/tb_cargador_programa.sv
`default_nettype none
// ============================================================================
// Module   : tb_cargador_programa
// Brief    : Directed self-checking bench for cargador_programa (both builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cargador_programa;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, ocupado, cargado, error;
    logic [7:0] Direccion = 8'h00;
    logic [7:0] B1, B2, B3, B4;

    int checks = 0;
    int errors = 0;

    cargador_programa #(.ANCHO_DIR(8), .ANCHO_DATO(8)) dut (
        .clk(clk), .reset(reset), .inicio(inicio),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ocupado(ocupado), .cargado(cargado), .error(error),
        .Direccion(Direccion), .B1(B1), .B2(B2), .B3(B3), .B4(B4)
    );

    always #5 clk = ~clk;

    // All drives and samples happen on the falling edge
    task automatic pulse_inicio;
        @(negedge clk); inicio = 1'b1;
        @(negedge clk); inicio = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) begin
            in_valid = 1'b0; in_data = 8'h5A;
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; inicio = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0; inicio = 1'b0;
        checks++;
        if ({in_ready, ocupado, cargado, error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", {in_ready, ocupado, cargado, error});
        end
        @(negedge clk);
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold ocupado got %b exp 0", ocupado);
        end
    endtask

    task automatic test_stream(input bit gap);
        pulse_inicio();
        checks++;
        if ({in_ready, ocupado, cargado} !== 3'b110) begin
            errors++;
            $display("FAIL stream_header gap=%0d got %b exp 110", gap, {in_ready, ocupado, cargado});
        end
        send(8'h04, gap); send(8'hA1, gap); send(8'hB2, gap); send(8'hC3, gap);
        send(8'hD4, gap);
`ifdef CARGA_CHECKSUM_EN
        checks++;
        if (cargado !== 1'b0) begin
            errors++;
            $display("FAIL stream_early_done gap=%0d cargado got %b exp 0", gap, cargado);
        end
        send(8'hEA, gap);
`endif
        checks++;
        if ({cargado, ocupado, in_ready, error} !== 4'b1000) begin
            errors++;
            $display("FAIL stream_done gap=%0d got %b exp 1000", gap, {cargado, ocupado, in_ready, error});
        end
        Direccion = 8'h00; #1;
        checks++;
        if ({B1, B2, B3, B4} !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL stream_mem gap=%0d got %h exp a1b2c3d4", gap, {B1, B2, B3, B4});
        end
    endtask

    task automatic test_full256;
        pulse_inicio();
        send(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            if (i == 100) inicio = 1'b1;
            send(8'(i), 1'b0);
            inicio = 1'b0;
        end
`ifdef CARGA_CHECKSUM_EN
        send(8'h80, 1'b0);
`endif
        checks++;
        if ({cargado, ocupado} !== 2'b10) begin
            errors++;
            $display("FAIL full_done got %b exp 10", {cargado, ocupado});
        end
        Direccion = 8'hFE; #1;
        checks++;
        if ({B1, B2, B3, B4} !== 32'hFEFF0001) begin
            errors++;
            $display("FAIL full_wrap got %h exp feff0001", {B1, B2, B3, B4});
        end
        Direccion = 8'h7F; #1;
        checks++;
        if ({B1, B2, B3, B4} !== 32'h7F808182) begin
            errors++;
            $display("FAIL full_mid got %h exp 7f808182", {B1, B2, B3, B4});
        end
    endtask

    task automatic test_reset_mid_load;
        pulse_inicio();
        send(8'h04, 1'b0); send(8'hA1, 1'b0); send(8'hB2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({ocupado, in_ready, cargado, error} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_state got %b exp 0000", {ocupado, in_ready, cargado, error});
        end
        send(8'h77, 1'b0);
        Direccion = 8'h00; #1;
        checks++;
        if ({B1, B2, B3} !== 24'hA1B202) begin
            errors++;
            $display("FAIL midreset_mem got %h exp a1b202", {B1, B2, B3});
        end
    endtask

    task automatic test_checksum;
        pulse_inicio();
`ifdef CARGA_CHECKSUM_EN
        send(8'h02, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h31, 1'b0);
        checks++;
        if ({error, ocupado, cargado, in_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL cksum_error got %b exp 1100", {error, ocupado, cargado, in_ready});
        end
        pulse_inicio();
        checks++;
        if ({error, ocupado, in_ready} !== 3'b011) begin
            errors++;
            $display("FAIL cksum_clear got %b exp 011", {error, ocupado, in_ready});
        end
        send(8'h01, 1'b0); send(8'h55, 1'b0); send(8'h55, 1'b0);
        checks++;
        if ({cargado, error} !== 2'b10) begin
            errors++;
            $display("FAIL cksum_recover got %b exp 10", {cargado, error});
        end
        Direccion = 8'h00; #1;
        checks++;
        if ({B1, B2, B3} !== 24'h551020) begin
            errors++;
            $display("FAIL cksum_mem got %h exp 551020", {B1, B2, B3});
        end
`else
        send(8'h02, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b0);
        checks++;
        if ({cargado, error, ocupado} !== 3'b100) begin
            errors++;
            $display("FAIL nocksum_done got %b exp 100", {cargado, error, ocupado});
        end
        Direccion = 8'hFF; #1;
        checks++;
        if ({B1, B2, B3, B4} !== 32'hFF102002) begin
            errors++;
            $display("FAIL nocksum_mem got %h exp ff102002", {B1, B2, B3, B4});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_full256();
        test_reset_mid_load();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
